miriscv_alu_ctrl: RTL and testbench

Multi-cycle execute controller on the driving side of the miriscv ALU. It accepts one RV32I instruction and its PC over a valid/ready handshake and reads rs1/rs2 from the register file. It decodes the instruction into an ALU operator and operands, drives the ALU, and captures result_o and comparison_result_o. It then emits a one-cycle writeback or branch-resolution pulse, and returns to idle.

---
 rtl/miriscv_alu_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_miriscv_alu_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_alu_ctrl.sv
// Multi-cycle RV32I execute controller: decodes one instruction, drives the ALU,
// then emits a single-cycle writeback / next-PC / illegal strobe.
module miriscv_alu_ctrl #(
    parameter int unsigned ALU_OPW      = 5,
    parameter logic [31:0] RESET_PC_INC = 32'd4
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    input  logic               instr_valid_i,
    output logic               instr_ready_o,
    input  logic [31:0]        instr_i,
    input  logic [31:0]        pc_i,
    output logic [4:0]         rs1_addr_o,
    output logic [4:0]         rs2_addr_o,
    input  logic [31:0]        rs1_data_i,
    input  logic [31:0]        rs2_data_i,
    output logic [ALU_OPW-1:0] alu_op_o,
    output logic [31:0]        alu_a_o,
    output logic [31:0]        alu_b_o,
    input  logic [31:0]        alu_result_i,
    input  logic               alu_cmp_i,
    output logic               wb_en_o,
    output logic [4:0]         wb_addr_o,
    output logic [31:0]        wb_data_o,
    output logic               pc_next_valid_o,
    output logic [31:0]        pc_next_o,
    output logic               illegal_o
);

    localparam logic [ALU_OPW-1:0] ALU_ADD = ALU_OPW'(5'b00000);
    localparam logic [ALU_OPW-1:0] ALU_SUB = ALU_OPW'(5'b01000);
    localparam logic [ALU_OPW-1:0] ALU_XOR = ALU_OPW'(5'b00100);
    localparam logic [ALU_OPW-1:0] ALU_OR  = ALU_OPW'(5'b00110);
    localparam logic [ALU_OPW-1:0] ALU_AND = ALU_OPW'(5'b00111);
    localparam logic [ALU_OPW-1:0] ALU_SRA = ALU_OPW'(5'b01101);
    localparam logic [ALU_OPW-1:0] ALU_SRL = ALU_OPW'(5'b00101);
    localparam logic [ALU_OPW-1:0] ALU_SLL = ALU_OPW'(5'b00001);
    localparam logic [ALU_OPW-1:0] ALU_LTS = ALU_OPW'(5'b11100);
    localparam logic [ALU_OPW-1:0] ALU_LTU = ALU_OPW'(5'b11110);
    localparam logic [ALU_OPW-1:0] ALU_GES = ALU_OPW'(5'b11101);
    localparam logic [ALU_OPW-1:0] ALU_GEU = ALU_OPW'(5'b11111);
    localparam logic [ALU_OPW-1:0] ALU_EQ  = ALU_OPW'(5'b11000);
    localparam logic [ALU_OPW-1:0] ALU_NE  = ALU_OPW'(5'b11001);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [1:0] {StIdle, StDecode, StExec, StWb} state_e;

    state_e state_q, state_d;

    logic               ready_q;
    logic [31:0]        instr_q, pc_q;
    logic [ALU_OPW-1:0] alu_op_q;
    logic [31:0]        alu_a_q, alu_b_q;
    logic               writes_q, branch_q, illegal_q;
    logic               wb_en_q, pc_next_valid_q, illegal_out_q;
    logic [4:0]         wb_addr_q;
    logic [31:0]        wb_data_q, pc_next_q;

    logic accept, decode_en, exec_en;

    // State register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (instr_valid_i && ready_q) state_d = StDecode;
            StDecode: state_d = StExec;
            StExec:   state_d = StWb;
            StWb:     state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Per-state enables
    always_comb begin
        accept    = (state_q == StIdle) && instr_valid_i && ready_q;
        decode_en = (state_q == StDecode);
        exec_en   = (state_q == StExec);
    end

    function automatic logic [ALU_OPW-1:0] arith_op(input logic [2:0] f3, input logic alt);
        logic [ALU_OPW-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_LTS;
            3'b011:  op = ALU_LTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]         opcode, funct7;
    logic [2:0]         funct3;
    logic [ALU_OPW-1:0] dec_op;
    logic [31:0]        dec_a, dec_b, b_imm;
    logic               dec_writes, dec_branch, dec_illegal;

    always_comb begin
        opcode      = instr_q[6:0];
        funct3      = instr_q[14:12];
        funct7      = instr_q[31:25];
        b_imm       = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                       instr_q[11:8], 1'b0};
        dec_op      = ALU_ADD;
        dec_a       = rs1_data_i;
        dec_b       = rs2_data_i;
        dec_writes  = 1'b0;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_writes  = 1'b1;
                dec_op      = arith_op(funct3, funct7 == F7_ALT);
                dec_illegal = !((funct7 == 7'b0) ||
                                (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                dec_writes = 1'b1;
                dec_b      = {{20{instr_q[31]}}, instr_q[31:20]};
                dec_op     = arith_op(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
                // Shifts carry shamt in imm[4:0]; the upper immediate bits are funct7
                if (funct3 == 3'b001) begin
                    dec_b       = {27'b0, instr_q[24:20]};
                    dec_illegal = (funct7 != 7'b0);
                end else if (funct3 == 3'b101) begin
                    dec_b       = {27'b0, instr_q[24:20]};
                    dec_illegal = !((funct7 == 7'b0) || (funct7 == F7_ALT));
                end
            end
            OPC_LUI: begin
                dec_writes = 1'b1;
                dec_a      = 32'b0;
                dec_b      = {instr_q[31:12], 12'b0};
            end
            OPC_BRANCH: begin
                dec_branch = 1'b1;
                case (funct3)
                    3'b000:  dec_op = ALU_EQ;
                    3'b001:  dec_op = ALU_NE;
                    3'b100:  dec_op = ALU_LTS;
                    3'b101:  dec_op = ALU_GES;
                    3'b110:  dec_op = ALU_LTU;
                    3'b111:  dec_op = ALU_GEU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_writes = 1'b0;
            dec_branch = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ready_q         <= 1'b0;
            instr_q         <= 32'b0;
            pc_q            <= 32'b0;
            alu_op_q        <= ALU_ADD;
            alu_a_q         <= 32'b0;
            alu_b_q         <= 32'b0;
            writes_q        <= 1'b0;
            branch_q        <= 1'b0;
            illegal_q       <= 1'b0;
            wb_en_q         <= 1'b0;
            wb_addr_q       <= 5'b0;
            wb_data_q       <= 32'b0;
            pc_next_valid_q <= 1'b0;
            pc_next_q       <= 32'b0;
            illegal_out_q   <= 1'b0;
        end else begin
            ready_q         <= (state_d == StIdle);
            wb_en_q         <= 1'b0;
            pc_next_valid_q <= 1'b0;
            illegal_out_q   <= 1'b0;
            if (accept) begin
                instr_q <= instr_i;
                pc_q    <= pc_i;
            end
            if (decode_en) begin
                alu_op_q  <= dec_op;
                alu_a_q   <= dec_a;
                alu_b_q   <= dec_b;
                writes_q  <= dec_writes;
                branch_q  <= dec_branch;
                illegal_q <= dec_illegal;
            end
            // ALU result is captured straight into the WB-cycle strobe registers
            if (exec_en) begin
                wb_en_q         <= writes_q && (instr_q[11:7] != 5'b0);
                wb_addr_q       <= instr_q[11:7];
                wb_data_q       <= alu_result_i;
                pc_next_valid_q <= 1'b1;
                pc_next_q       <= (branch_q && alu_cmp_i) ? pc_q + b_imm : pc_q + RESET_PC_INC;
                illegal_out_q   <= illegal_q;
            end
        end
    end

    assign instr_ready_o   = ready_q;
    assign rs1_addr_o      = instr_q[19:15];
    assign rs2_addr_o      = instr_q[24:20];
    assign alu_op_o        = alu_op_q;
    assign alu_a_o         = alu_a_q;
    assign alu_b_o         = alu_b_q;
    assign wb_en_o         = wb_en_q;
    assign wb_addr_o       = wb_addr_q;
    assign wb_data_o       = wb_data_q;
    assign pc_next_valid_o = pc_next_valid_q;
    assign pc_next_o       = pc_next_q;
    assign illegal_o       = illegal_out_q;

endmodule

// File: tb/tb_miriscv_alu_ctrl.sv
// Directed bench for miriscv_alu_ctrl with a behavioural ALU, a small register file and a
// scoreboard of expected WB-cycle results.
module tb_miriscv_alu_ctrl;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b01000;
    localparam logic [4:0] OP_XOR = 5'b00100;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_AND = 5'b00111;
    localparam logic [4:0] OP_SRA = 5'b01101;
    localparam logic [4:0] OP_SRL = 5'b00101;
    localparam logic [4:0] OP_SLL = 5'b00001;
    localparam logic [4:0] OP_LTS = 5'b11100;
    localparam logic [4:0] OP_LTU = 5'b11110;
    localparam logic [4:0] OP_GES = 5'b11101;
    localparam logic [4:0] OP_GEU = 5'b11111;
    localparam logic [4:0] OP_EQ  = 5'b11000;
    localparam logic [4:0] OP_NE  = 5'b11001;

    logic        clk_i = 1'b0;
    logic        arst_n_i = 1'b0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic [31:0] instr_i = 32'b0;
    logic [31:0] pc_i = 32'b0;
    logic [4:0]  rs1_addr_o, rs2_addr_o;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic [4:0]  alu_op_o;
    logic [31:0] alu_a_o, alu_b_o;
    logic [31:0] alu_result_i;
    logic        alu_cmp_i;
    logic        wb_en_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic        pc_next_valid_o;
    logic [31:0] pc_next_o;
    logic        illegal_o;

    logic [31:0] regs [32];

    miriscv_alu_ctrl dut (
        .clk_i          (clk_i),
        .arst_n_i       (arst_n_i),
        .instr_valid_i  (instr_valid_i),
        .instr_ready_o  (instr_ready_o),
        .instr_i        (instr_i),
        .pc_i           (pc_i),
        .rs1_addr_o     (rs1_addr_o),
        .rs2_addr_o     (rs2_addr_o),
        .rs1_data_i     (rs1_data_i),
        .rs2_data_i     (rs2_data_i),
        .alu_op_o       (alu_op_o),
        .alu_a_o        (alu_a_o),
        .alu_b_o        (alu_b_o),
        .alu_result_i   (alu_result_i),
        .alu_cmp_i      (alu_cmp_i),
        .wb_en_o        (wb_en_o),
        .wb_addr_o      (wb_addr_o),
        .wb_data_o      (wb_data_o),
        .pc_next_valid_o(pc_next_valid_o),
        .pc_next_o      (pc_next_o),
        .illegal_o      (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    assign rs1_data_i = (rs1_addr_o == 5'd0) ? 32'b0 : regs[rs1_addr_o];
    assign rs2_data_i = (rs2_addr_o == 5'd0) ? 32'b0 : regs[rs2_addr_o];

    // Behavioural ALU
    always_comb begin
        alu_cmp_i    = 1'b0;
        alu_result_i = 32'b0;
        case (alu_op_o)
            OP_ADD: alu_result_i = alu_a_o + alu_b_o;
            OP_SUB: alu_result_i = alu_a_o - alu_b_o;
            OP_XOR: alu_result_i = alu_a_o ^ alu_b_o;
            OP_OR:  alu_result_i = alu_a_o | alu_b_o;
            OP_AND: alu_result_i = alu_a_o & alu_b_o;
            OP_SLL: alu_result_i = alu_a_o << alu_b_o[4:0];
            OP_SRL: alu_result_i = alu_a_o >> alu_b_o[4:0];
            OP_SRA: alu_result_i = $unsigned($signed(alu_a_o) >>> alu_b_o[4:0]);
            OP_LTS: alu_cmp_i = $signed(alu_a_o) < $signed(alu_b_o);
            OP_LTU: alu_cmp_i = alu_a_o < alu_b_o;
            OP_GES: alu_cmp_i = $signed(alu_a_o) >= $signed(alu_b_o);
            OP_GEU: alu_cmp_i = alu_a_o >= alu_b_o;
            OP_EQ:  alu_cmp_i = alu_a_o == alu_b_o;
            OP_NE:  alu_cmp_i = alu_a_o != alu_b_o;
            default: alu_result_i = 32'b0;
        endcase
        if (alu_op_o[4:3] == 2'b11) alu_result_i = {31'b0, alu_cmp_i};
    end

    typedef struct {
        string       tag;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] pc_next;
        logic        illegal;
    } wb_t;

    wb_t sb [$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every next-PC strobe consumes one expectation
    always @(negedge clk_i) begin
        if (pc_next_valid_o) begin
            chk("wb_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                wb_t e;
                e = sb.pop_front();
                chk({e.tag, ".wb_en"}, 32'(wb_en_o), 32'(e.wb_en));
                if (e.wb_en) begin
                    chk({e.tag, ".wb_addr"}, 32'(wb_addr_o), 32'(e.wb_addr));
                    chk({e.tag, ".wb_data"}, wb_data_o, e.wb_data);
                end
                chk({e.tag, ".pc_next"}, pc_next_o, e.pc_next);
                chk({e.tag, ".illegal"}, 32'(illegal_o), 32'(e.illegal));
            end
        end else if (wb_en_o || illegal_o) begin
            chk("stray_strobe", {30'b0, wb_en_o, illegal_o}, 32'd0);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("ready_timeout", 32'(instr_ready_o), 32'd1);
    endtask

    // Offer one instruction at a negedge and follow it to the cycle after WB
    task automatic issue(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                         input bit chk_alu, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic wb, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [31:0] pn, input logic ill);
        wb_t e;
        wait_ready();
        instr_valid_i = 1'b1;
        instr_i       = instr;
        pc_i          = pc;
        e.tag = tag; e.wb_en = wb; e.wb_addr = wa; e.wb_data = wd; e.pc_next = pn;
        e.illegal = ill;
        sb.push_back(e);
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        chk({tag, ".ready_drop"}, 32'(instr_ready_o), 32'd0);
        chk({tag, ".rs1_addr"}, 32'(rs1_addr_o), 32'(instr[19:15]));
        chk({tag, ".rs2_addr"}, 32'(rs2_addr_o), 32'(instr[24:20]));
        @(negedge clk_i);
        if (chk_alu) begin
            chk({tag, ".alu_op"}, 32'(alu_op_o), 32'(op));
            chk({tag, ".alu_a"}, alu_a_o, a);
            chk({tag, ".alu_b"}, alu_b_o, b);
        end
        @(negedge clk_i);
        @(negedge clk_i);
        chk({tag, ".ready_back"}, 32'(instr_ready_o), 32'd1);
        chk({tag, ".strobe_clear"}, {29'b0, wb_en_o, pc_next_valid_o, illegal_o}, 32'd0);
    endtask

    initial begin
        int acc;
        int n;
        wb_t e;
        for (int i = 0; i < 32; i++) regs[i] = 32'b0;

        repeat (3) @(negedge clk_i);
        chk("rst.ready", 32'(instr_ready_o), 32'd0);
        chk("rst.alu_op", 32'(alu_op_o), 32'(OP_ADD));
        chk("rst.pc_next", pc_next_o, 32'd0);
        chk("rst.strobes", {29'b0, wb_en_o, pc_next_valid_o, illegal_o}, 32'd0);
        arst_n_i = 1'b1;
        #1 chk("rel.ready_low", 32'(instr_ready_o), 32'd0);
        @(negedge clk_i);
        chk("rel.ready_high", 32'(instr_ready_o), 32'd1);

        regs[1] = 32'd5; regs[2] = 32'd7;
        issue("add", 32'h002081B3, 32'h40, 1, OP_ADD, 5, 7, 1, 3, 32'd12, 32'h44, 0);
        issue("sub", 32'h402081B3, 32'h44, 1, OP_SUB, 5, 7, 1, 3, 32'hFFFFFFFE, 32'h48, 0);
        issue("addi", 32'hFFF00093, 32'h48, 1, OP_ADD, 0, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF,
              32'h4C, 0);

        regs[1] = 32'd9; regs[2] = 32'd9;
        issue("beq_t", 32'h00208463, 32'h100, 1, OP_EQ, 9, 9, 0, 0, 0, 32'h108, 0);
        regs[2] = 32'd8;
        issue("beq_nt", 32'h00208463, 32'h100, 1, OP_EQ, 9, 8, 0, 0, 0, 32'h104, 0);
        regs[1] = 32'd3; regs[2] = 32'd4;
        issue("bne_wrap", 32'hFE209EE3, 32'h0, 1, OP_NE, 3, 4, 0, 0, 0, 32'hFFFFFFFC, 0);
        issue("add_x0", 32'h00208033, 32'h200, 1, OP_ADD, 3, 4, 0, 0, 0, 32'h204, 0);
        issue("sltiu", 32'h0050B213, 32'h210, 1, OP_LTU, 3, 5, 1, 4, 32'd1, 32'h214, 0);

        issue("ill_zero", 32'h00000000, 32'h300, 0, OP_ADD, 0, 0, 0, 0, 0, 32'h304, 1);
        issue("ill_f7", 32'h022081B3, 32'h304, 0, OP_ADD, 0, 0, 0, 0, 0, 32'h308, 1);
        issue("ill_slli", 32'h40109093, 32'h308, 0, OP_ADD, 0, 0, 0, 0, 0, 32'h30C, 1);
        issue("ill_br", 32'h0020A463, 32'hFFFFFFFC, 0, OP_ADD, 0, 0, 0, 0, 0, 32'h0, 1);

        regs[1] = 32'h80000010;
        issue("srai", 32'h4030D293, 32'h400, 1, OP_SRA, 32'h80000010, 3, 1, 5, 32'hF0000002,
              32'h404, 0);
        issue("lui", 32'h123453B7, 32'h404, 1, OP_ADD, 0, 32'h12345000, 1, 7, 32'h12345000,
              32'h408, 0);

        // Reset asserted during EXEC: nothing pushed, so any strobe is flagged
        wait_ready();
        regs[1] = 32'd5; regs[2] = 32'd7;
        instr_valid_i = 1'b1; instr_i = 32'h002081B3; pc_i = 32'h600;
        @(negedge clk_i);
        instr_valid_i = 1'b0;
        @(negedge clk_i);
        arst_n_i = 1'b0;
        #1;
        chk("mid_rst.ready", 32'(instr_ready_o), 32'd0);
        chk("mid_rst.alu", {alu_op_o, alu_a_o[7:0], alu_b_o[7:0]}, 32'd0);
        chk("mid_rst.addr", {22'b0, rs1_addr_o, rs2_addr_o}, 32'd0);
        chk("mid_rst.strobes", {29'b0, wb_en_o, pc_next_valid_o, illegal_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        arst_n_i = 1'b1;
        #1 chk("mid_rel.ready_low", 32'(instr_ready_o), 32'd0);
        @(negedge clk_i);
        chk("mid_rel.ready_high", 32'(instr_ready_o), 32'd1);
        issue("post_rst", 32'h002081B3, 32'h600, 1, OP_ADD, 5, 7, 1, 3, 32'd12, 32'h604, 0);

        // Valid held high: one acceptance every fourth cycle
        wait_ready();
        instr_valid_i = 1'b1; instr_i = 32'hFFF00093; pc_i = 32'h500;
        e.tag = "b2b"; e.wb_en = 1'b1; e.wb_addr = 5'd1; e.wb_data = 32'hFFFFFFFF;
        e.pc_next = 32'h504; e.illegal = 1'b0;
        acc = 0;
        for (int c = 0; c < 16; c++) begin
            if (instr_ready_o) begin
                acc++;
                sb.push_back(e);
            end
            @(negedge clk_i);
        end
        instr_valid_i = 1'b0;
        chk("b2b.accepted", 32'(acc), 32'd4);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
